uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_framer_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx_framer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_framer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, transmitter FSM states and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int MAX_DATA_BITS = 9;

  // Word must be zero-extended by the caller so unused upper bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] word, input parity_t mode);
    return (^word) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Producer-side valid/ready handshake carrying one UART payload word.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering payload words ahead of the transmitter FSM.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Push is judged against occupancy before any same-cycle pop.
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_BITS payload LSB first, optional parity, STOP_BITS stops.
// Define UART_TX_FIFO_EN to buffer FIFO_DEPTH words ahead of the line; default is one word.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int      BAUD_RATE  = 115200,
  parameter int      CLOCK_RATE = 25_000_000,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_framer_if.slave   s_in,
  output logic              uart_tx,
  output logic              busy
);
  localparam int DIVIDER = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W   = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVIDER - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (DIVIDER < 2) begin : g_bad_divider
    $error("uart_tx_framer: CLOCK_RATE/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
    $error("uart_tx_framer: DATA_BITS must be 5..9 and STOP_BITS 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
      || !(PARITY inside {PARITY_NONE, PARITY_EVEN, PARITY_ODD})) begin : g_bad_cfg
    $error("uart_tx_framer: FIFO_DEPTH must be a power of two >= 2 and PARITY a known mode");
  end

  tx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_alive;

  logic                 w_tick;
  logic                 w_stop_end;
  logic                 w_fsm_ready;
  logic                 w_avail;
  logic                 w_take;
  logic                 w_queued;
  logic [DATA_BITS-1:0] w_word;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_stop_end  = (r_state == ST_STOP) && w_tick && (r_bit == STOP_LAST);
  // The final stop-bit cycle behaves like IDLE so a waiting word follows with no gap.
  assign w_fsm_ready = r_alive && ((r_state == ST_IDLE) || w_stop_end);
  assign w_take      = w_avail && w_fsm_ready;

`ifdef UART_TX_FIFO_EN
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (s_in.in_valid && s_in.in_ready),
    .i_wr_data (s_in.in_data),
    .i_pop     (w_take),
    .o_rd_data (w_word),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign s_in.in_ready = r_alive && !w_full;
  assign w_avail       = !w_empty;
  assign w_queued      = (w_count != '0);
`else
  assign s_in.in_ready = w_fsm_ready;
  assign w_avail       = s_in.in_valid;
  assign w_word        = s_in.in_data;
  assign w_queued      = 1'b0;
`endif

  assign uart_tx = r_tx;
  assign busy    = (r_state != ST_IDLE) || w_queued;

  // Payload shifter: loaded on handshake, advanced once per transmitted data bit.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_shift <= w_word;
      r_par   <= parity_bit(MAX_DATA_BITS'(w_word), PARITY);
    end else if ((r_state == ST_DATA) && w_tick) begin
      r_shift <= r_shift >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_cnt   <= ((r_state == ST_IDLE) || w_tick) ? '0 : r_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
              if (PARITY == PARITY_NONE) begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end else begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit == STOP_LAST) begin
              r_bit <= '0;
              if (w_take) begin
                r_state <= ST_START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer at 1 MHz clock / 100 kbaud (10 clocks per bit).
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int CR  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [255:0] wv, rv, bv;
  logic tx0, tx1, tx2, tx3;
  logic b0, b1, b2, b3;

  uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_framer_if #(.DATA_BITS(7)) if1 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if3 ();

  uart_tx_framer #(.BAUD_RATE(BR), .CLOCK_RATE(CR)) d0 (
    .clk(clk), .reset(rst), .s_in(if0), .uart_tx(tx0), .busy(b0));
  uart_tx_framer #(.BAUD_RATE(BR), .CLOCK_RATE(CR), .DATA_BITS(7), .PARITY(PARITY_EVEN)) d1 (
    .clk(clk), .reset(rst), .s_in(if1), .uart_tx(tx1), .busy(b1));
  uart_tx_framer #(.BAUD_RATE(BR), .CLOCK_RATE(CR), .PARITY(PARITY_ODD)) d2 (
    .clk(clk), .reset(rst), .s_in(if2), .uart_tx(tx2), .busy(b2));
  uart_tx_framer #(.BAUD_RATE(BR), .CLOCK_RATE(CR), .STOP_BITS(2)) d3 (
    .clk(clk), .reset(rst), .s_in(if3), .uart_tx(tx3), .busy(b3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int idx, input logic v, input logic [8:0] d);
    case (idx)
      0:       begin if0.in_valid = v; if0.in_data = d[7:0]; end
      1:       begin if1.in_valid = v; if1.in_data = d[6:0]; end
      2:       begin if2.in_valid = v; if2.in_data = d[7:0]; end
      default: begin if3.in_valid = v; if3.in_data = d[7:0]; end
    endcase
  endtask

  function automatic logic get_tx(input int idx);
    case (idx)
      0: return tx0;  1: return tx1;  2: return tx2;  default: return tx3;
    endcase
  endfunction

  function automatic logic get_rdy(input int idx);
    case (idx)
      0: return if0.in_ready;  1: return if1.in_ready;
      2: return if2.in_ready;  default: return if3.in_ready;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return b0;  1: return b1;  2: return b2;  default: return b3;
    endcase
  endfunction

  // Expected line waveform, one bit per clock, for a frame starting at sample pos.
  function automatic logic [255:0] add_frame(input logic [255:0] base, input int pos,
                                             input logic [8:0] d, input int nb,
                                             input int par, input int stops);
    logic [255:0] w;
    logic [11:0]  bits;
    logic         pb;
    int           n;
    w = base; bits = '0; pb = 1'b0; n = 1;
    for (int b = 0; b < nb; b++) begin
      bits[n] = d[b];
      pb ^= d[b];
      n++;
    end
    if (par != 0) begin
      bits[n] = (par == 2) ? ~pb : pb;
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int k = 0; k < n * DIV; k++) w[pos + k] = bits[k / DIV];
    return w;
  endfunction

  function automatic logic [15:0] mids(input logic [255:0] w, input int nb);
    logic [15:0] m;
    m = '0;
    for (int j = 0; j < nb; j++) m[j] = w[j * DIV + 5];
    return m;
  endfunction

  task automatic send(input int idx, input logic [8:0] d);
    @(negedge clk);
    set_in(idx, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
`ifdef UART_TX_FIFO_EN
    set_in(idx, 1'b0, d);
    @(negedge clk);
`endif
  endtask

  task automatic capture(input int idx, input int n, input int drop_at,
                         input int chg_at, input logic [8:0] chg_d);
    wv = '1; rv = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) set_in(idx, 1'b0, chg_d);
      if (i == chg_at)  set_in(idx, 1'b1, chg_d);
      wv[i] = get_tx(idx);
      rv[i] = get_rdy(idx);
      bv[i] = get_busy(idx);
      @(negedge clk);
    end
  endtask

`ifdef UART_TX_FIFO_EN
  int   acc;
  logic rd;
  logic [7:0] rx_d;

  task automatic rx0(output logic [7:0] d);
    int t;
    t = 0;
    d = '0;
    while (tx0 === 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("rx_start_seen", (t < 400), 1'b1);
    repeat (DIV / 2) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      repeat (DIV) @(negedge clk);
      d[b] = tx0;
    end
    repeat (DIV) @(negedge clk);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) set_in(i, 1'b0, 9'h000);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_rdy", if0.in_ready, 1'b0);
    chk("rst_busy", b0, 1'b0);
    rst = 1'b0;
    #1 chk("rdy_before_edge", if0.in_ready, 1'b0);
    @(posedge clk);
    #1 chk("rdy_after_edge", if0.in_ready, 1'b1);

    // 8N1, 0xA5
    send(0, 9'h0A5);
    capture(0, 120, 0, -1, 9'h000);
    chk("8n1_wave", wv, add_frame('1, 0, 9'h0A5, 8, 0, 1));
    chk("8n1_bits", mids(wv, 10), 16'h034A);
    chk("8n1_busy_mid", bv[50], 1'b1);
    chk("8n1_idle", {rv[110], bv[110], wv[119:100]}, {2'b10, 20'hFFFFF});
`ifndef UART_TX_FIFO_EN
    chk("8n1_rdy_in_frame", rv[98:0], 99'd0);
`endif

    // 7E1, 0x07
    send(1, 9'h007);
    capture(1, 120, 0, -1, 9'h000);
    chk("7e1_wave", wv, add_frame('1, 0, 9'h007, 7, 1, 1));
    chk("7e1_parity", wv[85], 1'b1);
    chk("7e1_len", {bv[99], bv[100]}, 2'b10);

    // 8O1, 0xFF
    send(2, 9'h0FF);
    capture(2, 130, 0, -1, 9'h000);
    chk("8o1_wave", wv, add_frame('1, 0, 9'h0FF, 8, 2, 1));
    chk("8o1_parity", wv[95], 1'b1);
    chk("8o1_len", {bv[109], bv[110]}, 2'b10);

`ifndef UART_TX_FIFO_EN
    // 8N2 back-to-back: second word waits on the handshake through the first frame
    send(3, 9'h000);
    set_in(3, 1'b1, 9'h0FF);
    capture(3, 240, 150, -1, 9'h0FF);
    chk("8n2_wave", wv, add_frame(add_frame('1, 0, 9'h000, 8, 0, 2), 110, 9'h0FF, 8, 0, 2));
    chk("8n2_gap", wv[110:90], 21'h0FFFFF);
`endif

    // Reset at cycle 35 of a frame (data bit 2 of 0xC3 is low)
    send(0, 9'h0C3);
    capture(0, 35, 0, -1, 9'h000);
    chk("pre_rst_tx", tx0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx0, 1'b1);
    chk("mid_rst_busy", b0, 1'b0);
    chk("mid_rst_rdy", if0.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_rdy", if0.in_ready, 1'b1);
    send(0, 9'h05A);
    capture(0, 120, 0, -1, 9'h000);
    chk("post_rst_wave", wv, add_frame('1, 0, 9'h05A, 8, 0, 1));

`ifndef UART_TX_FIFO_EN
    // in_valid held, in_data changed mid-frame: only the handshake value goes out
    send(0, 9'h096);
    capture(0, 120, 95, 30, 9'h00F);
    chk("hold_wave", wv, add_frame('1, 0, 9'h096, 8, 0, 1));
    chk("hold_idle", {rv[105], bv[105]}, 2'b10);
`else
    // 17 pushes into a 16-deep FIFO while the line is busy with the first word
    acc = 0;
    fork
      begin
        @(negedge clk);
        set_in(0, 1'b1, 9'h000);
        for (int c = 0; c < 40; c++) begin
          rd = if0.in_ready;
          @(negedge clk);
          if (rd) begin
            acc++;
            set_in(0, 1'b1, 9'(acc));
          end
        end
        set_in(0, 1'b0, 9'h000);
        chk("fifo_accepts", acc, 17);
        chk("fifo_full_rdy", if0.in_ready, 1'b0);
      end
      begin
        for (int k = 0; k < 17; k++) begin
          rx0(rx_d);
          chk($sformatf("fifo_word%0d", k), rx_d, k[7:0]);
        end
      end
    join
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
